// File: rtl/sub16_serial_if.sv
// Start/busy/done handshake and operand/result bundle between the ALU controller
// and the serial 16-bit subtractor.
interface sub16_serial_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        borrowIn;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrowOut;
  logic        overflow;
  logic        zero;

  modport master (
    output start, a, b, borrowIn,
    input  busy, done, diff, borrowOut, overflow, zero
  );

  modport slave (
    input  start, a, b, borrowIn,
    output busy, done, diff, borrowOut, overflow, zero
  );
endinterface

// File: rtl/sub16_serial.sv
// Serial 16-bit subtractor: computes a - b - borrowIn one nibble per clock through
// a single time-multiplexed 4-bit carry-lookahead slice, with borrow/overflow/zero flags.
module sub16_serial (
  input  logic           clk,
  input  logic           rst,
  sub16_serial_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, b_reg;
  logic [15:0] diff_reg, diff_next;
  logic        carry_reg;
  logic [1:0]  idx_reg;
  logic        borrow_out_reg, overflow_reg, zero_reg;
  logic        accept;

  logic [3:0]  a_nib, b_nib_n, nib_sum, g, p;
  logic [4:0]  c;

  // Subtraction is a + ~b + carry, where the carry is the inverted borrow.
  assign a_nib   = a_reg[{idx_reg, 2'b00} +: 4];
  assign b_nib_n = ~b_reg[{idx_reg, 2'b00} +: 4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pg
      assign g[gi]       = a_nib[gi] & b_nib_n[gi];
      assign p[gi]       = a_nib[gi] ^ b_nib_n[gi];
      assign nib_sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Fully expanded lookahead carries so the slice stays one level of AND-OR deep.
  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx_reg == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    diff_next = diff_reg;
    if (state_reg == RUN) begin
      diff_next[{idx_reg, 2'b00} +: 4] = nib_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= 16'h0000;
      b_reg          <= 16'h0000;
      diff_reg       <= 16'h0000;
      carry_reg      <= 1'b0;
      idx_reg        <= 2'd0;
      borrow_out_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      zero_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= bus.a;
        b_reg     <= bus.b;
        carry_reg <= ~bus.borrowIn;
        idx_reg   <= 2'd0;
      end else if (state_reg == RUN) begin
        diff_reg  <= diff_next;
        carry_reg <= c[4];
        idx_reg   <= idx_reg + 2'd1;
        // Flags are captured with the last nibble so they stay aligned with diff.
        if (idx_reg == 2'd3) begin
          borrow_out_reg <= ~c[4];
          overflow_reg   <= (a_reg[15] != b_reg[15]) && (diff_next[15] != a_reg[15]);
          zero_reg       <= (diff_next == 16'h0000);
        end
      end
    end
  end

  assign bus.busy      = (state_reg == RUN);
  assign bus.done      = (state_reg == DONE);
  assign bus.diff      = diff_reg;
  assign bus.borrowOut = borrow_out_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;

endmodule
